// File: rtl/router_pkg.sv
// Shared constants, helpers and types for the router output synchronizer.
// Holds default channel/address/timeout sizes and the timer-width helper.
package router_pkg;

    localparam int DEF_NUM_CH  = 3;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_TIMEOUT = 30;

    // Smallest width w with 2**w >= v (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    typedef logic [DEF_NUM_CH-1:0] ch_mask_t;

endpackage

// File: rtl/router_sync_n_if.sv
// Bus between router FSM / FIFOs / sinks and router_sync_n.
// master: drives detect_add, write_en_reg, data_in, full, empty, read_enb.
// slave : drives write_en, vld_out, soft_reset, fifo_full, addr_err
//         (and to_status when ROUTER_SYNC_TO_STATUS_EN is defined).
interface router_sync_n_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              detect_add;
    logic              write_en_reg;
    logic [ADDR_W-1:0] data_in;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] read_enb;
    logic [NUM_CH-1:0] write_en;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] soft_reset;
    logic              fifo_full;
    logic              addr_err;
`ifdef ROUTER_SYNC_TO_STATUS_EN
    logic [NUM_CH-1:0] to_status;
`endif

    modport master (
        output detect_add, write_en_reg, data_in,
        output full, empty, read_enb,
        input  write_en, vld_out, soft_reset,
        input  fifo_full, addr_err
`ifdef ROUTER_SYNC_TO_STATUS_EN
        , input to_status
`endif
    );

    modport slave (
        input  detect_add, write_en_reg, data_in,
        input  full, empty, read_enb,
        output write_en, vld_out, soft_reset,
        output fifo_full, addr_err
`ifdef ROUTER_SYNC_TO_STATUS_EN
        , output to_status
`endif
    );

endinterface

// File: rtl/router_sync_timer.sv
// Per-channel read-timeout timer: one-cycle soft_reset after TIMEOUT unread
// valid cycles. Ports: clk, rst (async low), vld, read_enb, soft_reset, fire.
module router_sync_timer #(
    parameter int TIMEOUT = 30,
    parameter int TMR_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset,
    // Terminal count reached this cycle; soft_reset rises on the next edge.
    output logic fire
);

    localparam logic [TMR_W-1:0] TERM = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] tmr;

    assign fire = vld && !read_enb && (tmr == TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr        <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= fire;
            // A read, an empty FIFO or a fired timeout all restart counting.
            if (!vld || read_enb || fire) tmr <= '0;
            else                          tmr <= tmr + 1'b1;
        end
    end

endmodule

// File: rtl/router_sync_n.sv
// N-channel synchronizer between router FSM and its output FIFOs.
// Ports: clk, rst (async low), bus (router_sync_n_if.slave): address latch,
// write steering, fifo_full, vld_out, per-channel timeout soft_reset, addr_err.
// Optional macro ROUTER_SYNC_TO_STATUS_EN adds sticky to_status timeout flags.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TMR_W   = clog2(DEF_TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    router_sync_n_if.slave bus
);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_err;
    logic [NUM_CH-1:0] we;
    logic              ff;
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               addr_q <= '0;
        else if (bus.detect_add) addr_q <= bus.data_in;
    end

    assign addr_err = (int'(addr_q) >= NUM_CH);

    // Steering uses the registered address, so a same-cycle header
    // still writes to the previously selected FIFO.
    always_comb begin
        we = '0;
        ff = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!addr_err && addr_q == ADDR_W'(i)) begin
                we[i] = bus.write_en_reg;
                ff    = bus.full[i];
            end
        end
    end

    assign vld = ~bus.empty;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_tmr
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .TMR_W   (TMR_W)
        ) u_tmr (
            .clk        (clk),
            .rst        (rst),
            .vld        (vld[g]),
            .read_enb   (bus.read_enb[g]),
            .soft_reset (sr[g]),
            .fire       (fire[g])
        );
    end

    assign bus.write_en   = we;
    assign bus.fifo_full  = ff;
    assign bus.addr_err   = addr_err;
    assign bus.vld_out    = vld;
    assign bus.soft_reset = sr;

`ifdef ROUTER_SYNC_TO_STATUS_EN
    logic [NUM_CH-1:0] to_status_q;

    // Set on the edge that raises soft_reset; a new header clears,
    // but a coincident timeout still wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) to_status_q <= '0;
        else      to_status_q <= (bus.detect_add ? '0 : to_status_q) | fire;
    end

    assign bus.to_status = to_status_q;
`else
    logic unused_fire;
    assign unused_fire = ^fire;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// Directed self-checking bench for router_sync_n (3-channel default build,
// plus a 4-channel/TIMEOUT=8 instance when ROUTER_SYNC_TO_STATUS_EN is set).
module tb_router_sync_n;
    import router_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

    router_sync_n #(
        .NUM_CH  (3),
        .ADDR_W  (2),
        .TIMEOUT (30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef ROUTER_SYNC_TO_STATUS_EN
    router_sync_n_if #(.NUM_CH(4), .ADDR_W(2)) bus4 ();

    router_sync_n #(
        .NUM_CH  (4),
        .ADDR_W  (2),
        .TIMEOUT (8),
        .TMR_W   (3)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 time units past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        ch_mask_t m;
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        bus.detect_add   = 1'b0;
        bus.write_en_reg = 1'b0;
        bus.data_in      = '0;
        bus.full         = '0;
        bus.empty        = '1;
        bus.read_enb     = '0;
`ifdef ROUTER_SYNC_TO_STATUS_EN
        bus4.detect_add   = 1'b0;
        bus4.write_en_reg = 1'b0;
        bus4.data_in      = '0;
        bus4.full         = '0;
        bus4.empty        = '1;
        bus4.read_enb     = '0;
`endif
        #1;
        check("rst_write_en", bus.write_en, 3'b000);
        check("rst_soft_reset", bus.soft_reset, 3'b000);
        check("rst_addr_err", bus.addr_err, 1'b0);
        check("rst_vld_out", bus.vld_out, 3'b000);
        cyc(1);
        rst = 1'b1;
        cyc(1);

        // Address latch; same-cycle write still uses old address 0.
        bus.detect_add   = 1'b1;
        bus.data_in      = 2'd2;
        bus.write_en_reg = 1'b1;
        bus.full         = 3'b100;
        #1;
        check("we_old_addr", bus.write_en, 3'b001);
        check("ff_old_addr", bus.fifo_full, 1'b0);
        cyc(1);
        bus.detect_add = 1'b0;
        #1;
        check("we_addr2", bus.write_en, 3'b100);
        check("ff_addr2", bus.fifo_full, 1'b1);
        bus.write_en_reg = 1'b0;
        #1;
        check("we_idle", bus.write_en, 3'b000);

        // Channel 0 unread timeout, then a second pulse 30 cycles later.
        bus.empty = 3'b110;
        #1;
        check("vld_ch0", bus.vld_out, 3'b001);
        cyc(29);
        check("to_29", bus.soft_reset, 3'b000);
        cyc(1);
        check("to_30", bus.soft_reset, 3'b001);
        cyc(1);
        check("to_pulse_end", bus.soft_reset, 3'b000);
        cyc(28);
        check("to2_59", bus.soft_reset, 3'b000);
        cyc(1);
        check("to2_60", bus.soft_reset, 3'b001);
        bus.empty = 3'b111;
        cyc(1);

        // Read at cycle 29 restarts the count.
        bus.empty = 3'b110;
        cyc(28);
        bus.read_enb = 3'b001;
        cyc(1);
        check("rd29_nopulse", bus.soft_reset, 3'b000);
        bus.read_enb = 3'b000;
        cyc(29);
        check("rd29_after29", bus.soft_reset, 3'b000);
        cyc(1);
        check("rd29_after30", bus.soft_reset, 3'b001);
        bus.empty = 3'b111;
        cyc(1);

        // Read on the terminal-count cycle wins.
        bus.empty = 3'b110;
        cyc(29);
        bus.read_enb = 3'b001;
        cyc(1);
        check("rd_term", bus.soft_reset, 3'b000);
        bus.read_enb = 3'b000;
        cyc(29);
        check("rd_term_29", bus.soft_reset, 3'b000);
        cyc(1);
        check("rd_term_30", bus.soft_reset, 3'b001);
        bus.empty = 3'b111;
        cyc(1);

        // Empty rising on the terminal-count cycle suppresses the pulse.
        bus.empty = 3'b110;
        cyc(29);
        bus.empty = 3'b111;
        cyc(1);
        check("empty_term", bus.soft_reset, 3'b000);

        // Invalid address.
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd3;
        cyc(1);
        bus.detect_add   = 1'b0;
        bus.write_en_reg = 1'b1;
        bus.full         = 3'b111;
        #1;
        check("aerr_flag", bus.addr_err, 1'b1);
        check("aerr_we", bus.write_en, 3'b000);
        check("aerr_ff", bus.fifo_full, 1'b0);
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd1;
        cyc(1);
        bus.detect_add = 1'b0;
        #1;
        check("addr1_err", bus.addr_err, 1'b0);
        check("addr1_we", bus.write_en, 3'b010);
        check("addr1_ff", bus.fifo_full, 1'b1);
        bus.write_en_reg = 1'b0;
        bus.full         = 3'b000;

        // Reset in the middle of an unread window.
        bus.empty = 3'b110;
        cyc(20);
        rst = 1'b0;
        #1;
        check("mid_rst_sr", bus.soft_reset, 3'b000);
        check("mid_rst_addr", bus.write_en | {2'b00, bus.addr_err}, 3'b000);
        cyc(1);
        rst = 1'b1;
        cyc(29);
        check("post_rst_29", bus.soft_reset, 3'b000);
        cyc(1);
        check("post_rst_30", bus.soft_reset, 3'b001);
        bus.empty = 3'b111;
        cyc(1);

`ifdef ROUTER_SYNC_TO_STATUS_EN
        check("ts_before_clr", bus.to_status, 3'b001);
        bus.detect_add = 1'b1;
        cyc(1);
        bus.detect_add = 1'b0;
        #1;
        check("ts_cleared", bus.to_status, 3'b000);
        bus.empty = 3'b101;
        cyc(29);
        check("ts_ch1_29", bus.to_status, 3'b000);
        cyc(1);
        check("ts_ch1_sr", bus.soft_reset, 3'b010);
        check("ts_ch1_set", bus.to_status, 3'b010);
        bus.empty = 3'b111;
        cyc(5);
        check("ts_ch1_held", bus.to_status, 3'b010);
        bus.detect_add = 1'b1;
        cyc(1);
        bus.detect_add = 1'b0;
        #1;
        check("ts_ch1_clr", bus.to_status, 3'b000);

        m = 3'b000;
        check("ts4_pre", bus4.to_status, 4'b0000);
        bus4.empty = 4'b0111;
        cyc(7);
        check("ts4_sr7", bus4.soft_reset, 4'b0000);
        cyc(1);
        check("ts4_sr8", bus4.soft_reset, 4'b1000);
        check("ts4_set", bus4.to_status, 4'b1000);
        bus4.empty = 4'b1111;
`else
        m = 3'b001;
`endif
        check("no_pulse_idle", bus.soft_reset & m, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
